// File: rtl/axis_frame_checker_if.sv
// AXI-Stream bundle seen by the frame checker: payload, handshake, tlast and tuser.
// The master side drives the beat; the slave side returns tready.
interface axis_frame_checker_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output tdata, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tlast, tuser,
      output tready
   );
endinterface

// File: rtl/axis_frame_checker.sv
// Receive-side AXI-Stream checker: throttles tready with an LFSR, checks an incrementing
// payload, frame length and tuser, and keeps saturating frame/beat/error counters.
module axis_frame_checker #(
   parameter int         DATA_WIDTH  = 8,
   parameter int         FRAME_LEN   = 16,
   parameter int         COUNT_WIDTH = 16,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   throttle_en,
   input  logic                   clear,
   axis_frame_checker_if.slave    s_axis,
   output logic [COUNT_WIDTH-1:0] frame_count,
   output logic [COUNT_WIDTH-1:0] beat_count,
   output logic [COUNT_WIDTH-1:0] error_count,
   output logic                   err_data,
   output logic                   err_len,
   output logic                   err_user,
   output logic                   sticky_error
);

   localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic {
      IN_FRAME,
      DISCARD
   } state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      beat_idx, beat_idx_nxt;
   logic [DATA_WIDTH-1:0] expected, expected_nxt;
   logic [7:0]            lfsr;
   logic                  tready_q;
   logic                  accept;
   logic                  frame_done;
   logic                  data_bad, len_bad, user_bad;
   logic [1:0]            err_inc;

   // Adds 0..3 to a counter, pinning at all-ones instead of wrapping.
   function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                      input logic [1:0]             b);
      logic [COUNT_WIDTH+1:0] s;
      s = {2'b00, a} + {{COUNT_WIDTH{1'b0}}, b};
      if (s[COUNT_WIDTH+1:COUNT_WIDTH] != 2'b00)
         return '1;
      return s[COUNT_WIDTH-1:0];
   endfunction

   assign s_axis.tready = tready_q;
   assign accept        = s_axis.tvalid & tready_q;
   assign frame_done    = accept & s_axis.tlast;
   assign err_inc       = {1'b0, data_bad} + {1'b0, len_bad} + {1'b0, user_bad};

   // Free-running LFSR (x^8+x^6+x^5+x^4+1); clear deliberately leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr     <= LFSR_SEED;
         tready_q <= 1'b0;
      end else begin
         lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         tready_q <= enable & (~throttle_en | lfsr[0]);
      end
   end

   always_comb begin
      state_nxt    = state;
      beat_idx_nxt = beat_idx;
      expected_nxt = expected;
      data_bad     = 1'b0;
      len_bad      = 1'b0;
      user_bad     = 1'b0;
      if (accept) begin
         user_bad = s_axis.tuser;
         case (state)
            IN_FRAME: begin
               // Resyncing to tdata+1 also covers the match case and limits errors to one per jump.
               data_bad     = (s_axis.tdata != expected);
               expected_nxt = s_axis.tdata + DATA_WIDTH'(1);
               if (s_axis.tlast) begin
                  len_bad      = (beat_idx != LAST_IDX);
                  beat_idx_nxt = '0;
               end else if (beat_idx == LAST_IDX) begin
                  len_bad      = 1'b1;
                  beat_idx_nxt = '0;
                  state_nxt    = DISCARD;
               end else begin
                  beat_idx_nxt = beat_idx + IDX_W'(1);
               end
            end
            DISCARD: begin
               if (s_axis.tlast) begin
                  beat_idx_nxt = '0;
                  state_nxt    = IN_FRAME;
               end
            end
            default: state_nxt = IN_FRAME;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IN_FRAME;
         beat_idx <= '0;
         expected <= '0;
      end else if (clear) begin
         state    <= IN_FRAME;
         beat_idx <= '0;
         expected <= '0;
      end else begin
         state    <= state_nxt;
         beat_idx <= beat_idx_nxt;
         expected <= expected_nxt;
      end
   end

   // A clear in the same cycle as an accepted beat wins, so that beat never reaches the stats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count  <= '0;
         beat_count   <= '0;
         error_count  <= '0;
         err_data     <= 1'b0;
         err_len      <= 1'b0;
         err_user     <= 1'b0;
         sticky_error <= 1'b0;
      end else if (clear) begin
         frame_count  <= '0;
         beat_count   <= '0;
         error_count  <= '0;
         err_data     <= 1'b0;
         err_len      <= 1'b0;
         err_user     <= 1'b0;
         sticky_error <= 1'b0;
      end else begin
         err_data <= data_bad;
         err_len  <= len_bad;
         err_user <= user_bad;
         if (accept)
            beat_count <= sat_add(beat_count, 2'd1);
         if (frame_done)
            frame_count <= sat_add(frame_count, 2'd1);
         if (err_inc != 2'd0) begin
            error_count  <= sat_add(error_count, err_inc);
            sticky_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: frame table plus hand sequences, with a
// strobe scoreboard, a tready reference and a 2-bit-counter instance for saturation.
module tb_axis_frame_checker;

   localparam int DW = 8;
   localparam int FL = 16;
   localparam int CW = 16;

   typedef struct {
      int         len;
      int         bad_idx;
      logic [7:0] bad_val;
      bit         resync;
      int         user_idx;
      int         exp_frames;
      int         exp_beats;
      int         exp_errs;
   } frame_vec_t;

   logic clk = 1'b0;
   logic rst, enable, throttle_en, clear;

   axis_frame_checker_if #(.DATA_WIDTH(DW)) bus ();
   axis_frame_checker_if #(.DATA_WIDTH(DW)) sat_bus ();

   logic [CW-1:0] frame_count, beat_count, error_count;
   logic          err_data, err_len, err_user, sticky_error;
   logic [1:0]    sat_frames, sat_beats, sat_errs;
   logic          sat_ed, sat_el, sat_eu, sat_sticky;

   always #5 clk = ~clk;

   axis_frame_checker #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .COUNT_WIDTH(CW), .LFSR_SEED(8'hA5)) dut (
      .clk(clk), .rst(rst), .enable(enable), .throttle_en(throttle_en), .clear(clear),
      .s_axis(bus),
      .frame_count(frame_count), .beat_count(beat_count), .error_count(error_count),
      .err_data(err_data), .err_len(err_len), .err_user(err_user), .sticky_error(sticky_error)
   );

   axis_frame_checker #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .COUNT_WIDTH(2), .LFSR_SEED(8'hA5)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .throttle_en(throttle_en), .clear(clear),
      .s_axis(sat_bus),
      .frame_count(sat_frames), .beat_count(sat_beats), .error_count(sat_errs),
      .err_data(sat_ed), .err_len(sat_el), .err_user(sat_eu), .sticky_error(sat_sticky)
   );

   assign sat_bus.tdata  = bus.tdata;
   assign sat_bus.tvalid = bus.tvalid;
   assign sat_bus.tlast  = bus.tlast;
   assign sat_bus.tuser  = bus.tuser;

   int          checks = 0;
   int          passes = 0;
   logic [2:0]  sb[$];
   bit          acc_flag = 1'b0;
   logic [7:0]  m_lfsr;
   logic        m_rdy;
   logic [7:0]  m_exp;
   int          m_idx;
   bit          m_disc;
   frame_vec_t  tbl[10];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int satv(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   // Reference tready: registered enable/throttle gate over the seeded LFSR.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr <= 8'hA5;
         m_rdy  <= 1'b0;
      end else begin
         m_rdy  <= enable & (~throttle_en | m_lfsr[0]);
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   // Strobes must match the scoreboard exactly one cycle after an accepted beat, else stay low.
   always @(posedge clk) begin
      logic [2:0] e;
      #1;
      checkOutput("tready", bus.tready, m_rdy);
      if (acc_flag) begin
         acc_flag = 1'b0;
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            checkOutput("strobes", {err_data, err_len, err_user}, e);
            checkOutput("sat_strobes", {sat_ed, sat_el, sat_eu}, e);
         end
      end else begin
         checkOutput("strobes_idle", {err_data, err_len, err_user}, 3'b000);
      end
   end

   task automatic resetModel();
      m_exp  = 8'h00;
      m_idx  = 0;
      m_disc = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic applyStimulus(input logic [7:0] data, input bit last, input bit user);
      int   waits;
      logic d, l;
      bus.tdata  = data;
      bus.tlast  = last;
      bus.tuser  = user;
      bus.tvalid = 1'b1;
      waits = 0;
      while (!bus.tready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!bus.tready) begin
         checkOutput("tready_timeout", 32'd0, 32'd1);
         bus.tvalid = 1'b0;
         return;
      end
      d = 1'b0;
      l = 1'b0;
      if (!m_disc) begin
         d     = (data != m_exp);
         m_exp = data + 8'd1;
         if (last) begin
            l     = (m_idx != FL - 1);
            m_idx = 0;
         end else if (m_idx == FL - 1) begin
            l      = 1'b1;
            m_disc = 1'b1;
            m_idx  = 0;
         end else begin
            m_idx++;
         end
      end else if (last) begin
         m_disc = 1'b0;
         m_idx  = 0;
      end
      sb.push_back({d, l, user});
      acc_flag = 1'b1;
      @(negedge clk);
      bus.tvalid = 1'b0;
      bus.tlast  = 1'b0;
      bus.tuser  = 1'b0;
   endtask

   task automatic checkCounts(input string tag, input int f, input int b, input int e);
      checkOutput({tag, "_frames"}, frame_count, f);
      checkOutput({tag, "_beats"}, beat_count, b);
      checkOutput({tag, "_errors"}, error_count, e);
      checkOutput({tag, "_sticky"}, sticky_error, (e != 0));
      checkOutput({tag, "_sat_frames"}, sat_frames, satv(f));
      checkOutput({tag, "_sat_beats"}, sat_beats, satv(b));
      checkOutput({tag, "_sat_errors"}, sat_errs, satv(e));
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] seq;
      logic [7:0] d;
      bit         chk;

      tbl[0] = '{16, -1, 8'h00, 1'b0, -1,  1,  16,  0};
      tbl[1] = '{16, -1, 8'h00, 1'b0, -1,  2,  32,  0};
      tbl[2] = '{16,  5, 8'hFF, 1'b0, -1,  3,  48,  2};
      tbl[3] = '{ 4, -1, 8'h00, 1'b0, -1,  4,  52,  3};
      tbl[4] = '{20, -1, 8'h00, 1'b0, 18,  5,  72,  5};
      tbl[5] = '{16, -1, 8'h00, 1'b0, 10,  6,  88,  6};
      tbl[6] = '{ 4,  3, 8'hEE, 1'b1,  3,  7,  92,  9};
      tbl[7] = '{16, -1, 8'h00, 1'b0, -1,  8, 108,  9};
      tbl[8] = '{16, -1, 8'h00, 1'b0, -1,  9, 124,  9};
      tbl[9] = '{17, -1, 8'h00, 1'b0, -1, 10, 141, 10};

      rst         = 1'b1;
      enable      = 1'b0;
      throttle_en = 1'b0;
      clear       = 1'b0;
      bus.tdata   = '0;
      bus.tvalid  = 1'b0;
      bus.tlast   = 1'b0;
      bus.tuser   = 1'b0;
      resetModel();
      repeat (2) @(negedge clk);
      checkCounts("reset", 0, 0, 0);
      checkOutput("reset_tready", bus.tready, 1'b0);
      checkOutput("reset_strobes", {err_data, err_len, err_user}, 3'b000);
      rst = 1'b0;

      // Ready gating: one-cycle registered response to enable.
      repeat (3) @(negedge clk);
      checkOutput("gate_off", bus.tready, 1'b0);
      enable = 1'b1;
      #1 checkOutput("gate_on_same_cycle", bus.tready, 1'b0);
      @(negedge clk);
      checkOutput("gate_on", bus.tready, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("gate_hold", bus.tready, 1'b1);
      enable = 1'b0;
      @(negedge clk);
      checkOutput("gate_drop", bus.tready, 1'b0);
      enable = 1'b1;
      @(negedge clk);

      seq = 8'h00;
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < tbl[r].len; i++) begin
            chk = (i < FL);
            if (!chk)
               d = 8'hC3;
            else if (i == tbl[r].bad_idx)
               d = tbl[r].bad_val;
            else
               d = seq;
            if (chk) begin
               if (i == tbl[r].bad_idx && tbl[r].resync)
                  seq = tbl[r].bad_val + 8'd1;
               else
                  seq = seq + 8'd1;
            end
            applyStimulus(d, (i == tbl[r].len - 1), (i == tbl[r].user_idx));
         end
         checkCounts($sformatf("row%0d", r), tbl[r].exp_frames, tbl[r].exp_beats, tbl[r].exp_errs);
      end

      // Throttled stream: 64 beats in 4 frames, tuser on beat 10.
      throttle_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         applyStimulus(seq, ((i % FL) == FL - 1), (i == 10));
         seq = seq + 8'd1;
      end
      checkCounts("throttle", 14, 205, 11);
      throttle_en = 1'b0;
      repeat (2) @(negedge clk);

      // Clear mid-frame, colliding with an accepted beat.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(seq, 1'b0, 1'b0);
         seq = seq + 8'd1;
      end
      checkOutput("pre_clear_tready", bus.tready, 1'b1);
      clear      = 1'b1;
      bus.tdata  = 8'h77;
      bus.tuser  = 1'b1;
      bus.tlast  = 1'b1;
      bus.tvalid = 1'b1;
      @(negedge clk);
      clear      = 1'b0;
      bus.tvalid = 1'b0;
      bus.tuser  = 1'b0;
      bus.tlast  = 1'b0;
      resetModel();
      checkCounts("clear", 0, 0, 0);
      for (int i = 0; i < FL; i++)
         applyStimulus(8'(i), (i == FL - 1), 1'b0);
      checkCounts("after_clear", 1, 16, 0);

      // Async reset mid-frame.
      for (int i = 0; i < 5; i++)
         applyStimulus(8'(FL + i), 1'b0, 1'b0);
      checkOutput("pre_reset_beats", beat_count, 21);
      #2 rst = 1'b1;
      #1;
      checkCounts("async_reset", 0, 0, 0);
      checkOutput("async_reset_tready", bus.tready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      for (int i = 0; i < FL; i++)
         applyStimulus(8'(i), (i == FL - 1), 1'b0);
      checkCounts("after_reset", 1, 16, 0);

      repeat (2) @(negedge clk);
      checkOutput("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- Single-clock AXI-Stream sink that consumes fixed-length test frames, generates a tready backpressure pattern, and checks payload, length and tuser.
- Sits at the m_axis end of the stream datapath (e.g. behind axis_async_fifo on the output side).
- Used as a synthesizable receive-side checker for soak tests and for self-checking benches.
- Exposes saturating frame, beat and error counters plus single-cycle error strobes.

Parameters:
DATA_WIDTH, 8, tdata width in bits (1..32).
FRAME_LEN, 16, expected beats per frame (>=1); tlast required on beat FRAME_LEN.
COUNT_WIDTH, 16, width of each status counter.
LFSR_SEED, 8'hA5, non-zero reset value of the throttle LFSR.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  when low, tready is held low and nothing is consumed.
throttle_en  input  1  when high, tready follows the LFSR pattern.
clear  input  1  synchronous; zeroes counters, sticky flag and expected data.
s_axis_tdata  input  DATA_WIDTH  stream payload.
s_axis_tvalid  input  1  beat valid.
s_axis_tready  output  1  registered ready.
s_axis_tlast  input  1  end of frame.
s_axis_tuser  input  1  bad-frame marker; any beat with tuser=1 is an error.
frame_count  output  COUNT_WIDTH  frames completed (tlast accepted).
beat_count  output  COUNT_WIDTH  beats accepted.
error_count  output  COUNT_WIDTH  error events (sum of strobes; 1 per strobe, max 1 increment per strobe per cycle).
err_data  output  1  one-cycle pulse on a data mismatch.
err_len  output  1  one-cycle pulse on a short or long frame.
err_user  output  1  one-cycle pulse on a beat with tuser=1.
sticky_error  output  1  set by any strobe; cleared only by rst or clear.

Behaviour:
- Reset values: tready=0, all counters=0, strobes=0, sticky_error=0, lfsr=LFSR_SEED, expected=0, beat_idx=0, state=IN_FRAME.
- Beat accept: tvalid & tready at a rising edge. tready is a register, so any change to enable or throttle_en shows on tready one cycle later.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle after reset.
  - next tready = enable & (~throttle_en | lfsr[0]).
  - clear does not reset the LFSR.
- Data check:
  - On each accepted beat in IN_FRAME, compare tdata with the expected register (DATA_WIDTH bits, wraps modulo 2^DATA_WIDTH).
  - Mismatch: err_data pulses next cycle and expected resyncs to tdata+1 (one error per discontinuity).
  - Match: expected increments.
  - Expected runs continuously across frame boundaries.
- States:
  - IN_FRAME: beat_idx counts accepted beats from 0.
    - tlast with beat_idx==FRAME_LEN-1: good frame; frame_count++, beat_idx=0.
    - tlast with beat_idx<FRAME_LEN-1: err_len (short); frame_count++, beat_idx=0.
    - No tlast with beat_idx==FRAME_LEN-1: err_len (long); go to DISCARD.
  - DISCARD: accepted beats are counted in beat_count but not data-checked. Expected is not advanced. On tlast: frame_count++, beat_idx=0, return to IN_FRAME.
- err_user is checked in both states.
- Simultaneous strobes: several may pulse in the same cycle. error_count adds their number (1..3), saturating.
- All counters saturate at all-ones and never wrap.
- clear takes priority over a beat accepted in the same cycle; that beat is discarded from statistics. After clear, expected=0, beat_idx=0, state=IN_FRAME.
- Reset mid-frame: all state returns to reset values immediately. The next accepted beat is treated as beat 0 of a new frame with expected=0.
- Strobe latency: exactly 1 cycle after the accepting edge. Counters update on that same edge.

Test Plan:
- Ready gating: enable=1, throttle_en=0 -> tready=1 one cycle later and stays high. enable=0 -> tready=0 next cycle.
- Good frame: two frames of data 0..15 then 16..31, FRAME_LEN=16, tlast on beat 16 of each -> frame_count=2, beat_count=32, error_count=0, sticky_error=0.
- Data error: frame 0..15 with beat 5 = 8'hFF -> single err_data pulse. Remaining beats 6..15 are flagged by one more pulse only (resync to 0x00 at 8'hFF+1, mismatch at 6), so error_count=2 and frame_count=1.
- Short then long frame: tlast on beat 4, then a 20-beat frame -> err_len pulses twice, frame_count=2, beat_count=24, beats 17..20 not data-checked.
- Throttle and user: throttle_en=1, 64 beats with tvalid held high and tuser=1 on beat 10 -> tready follows lfsr[0] (seed 0xA5) delayed by one cycle, no beat lost or duplicated, exactly one err_user.
- Clear and reset: counters near saturation (force 0xFFFE), 3 errors -> error_count=0xFFFF. clear -> all zero. Async rst mid-frame -> outputs at reset values within the same cycle.
